// File: rtl/pcs_descrambler_param.sv
// Self-synchronising 1 + x^39 + x^58 descrambler for the 64b/66b receive path.
// Carries a 58-bit history across words, with a ready/valid output stage, bypass, trust flag and header-error count.
module pcs_descrambler_param #(
    parameter int DATA_W    = 64,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [1:0]           in_hdr,
    input  logic                 bypass,
    input  logic                 resync,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [1:0]           out_hdr,
    output logic                 out_trusted,
    output logic                 out_hdr_err,
    output logic [ERR_CNT_W-1:0] hdr_err_cnt
);

    localparam int HIST_W = 58;
    localparam int EXT_W  = HIST_W + DATA_W;

    function automatic logic hdr_bad(input logic [1:0] h);
        return (h == 2'b00) || (h == 2'b11);
    endfunction

    logic [HIST_W-1:0] hist_r;
    logic [HIST_W-1:0] hist_eff_s;
    logic [HIST_W-1:0] hist_next_s;
    logic [5:0]        cnt_r;
    logic [5:0]        cnt_eff_s;
    logic [5:0]        cnt_next_s;
    logic [31:0]       cnt_sum_s;
    logic [EXT_W-1:0]  ext_s;
    logic [DATA_W-1:0] descr_s;
    logic              accept_s;

    assign in_ready = !out_valid || out_ready;
    assign accept_s = in_valid && in_ready;

    // Lay history and payload out as one serial window (index 0 = oldest bit) and descramble across it.
    always_comb begin
        hist_eff_s  = resync ? {HIST_W{1'b0}} : hist_r;
        cnt_eff_s   = resync ? 6'd0 : cnt_r;
        ext_s       = {EXT_W{1'b0}};
        descr_s     = {DATA_W{1'b0}};
        hist_next_s = {HIST_W{1'b0}};
        ext_s[EXT_W-1:HIST_W] = in_data;
        for (int k = 0; k < HIST_W; k++) begin
            ext_s[HIST_W-1-k] = hist_eff_s[k];
        end
        for (int i = 0; i < DATA_W; i++) begin
            descr_s[i] = ext_s[HIST_W+i] ^ ext_s[HIST_W+i-39] ^ ext_s[i];
        end
        for (int k = 0; k < HIST_W; k++) begin
            hist_next_s[k] = ext_s[EXT_W-1-k];
        end
        cnt_sum_s = 32'(cnt_eff_s) + 32'(DATA_W);
        if (cnt_sum_s >= 32'd58) begin
            cnt_next_s = 6'd58;
        end else begin
            cnt_next_s = cnt_sum_s[5:0];
        end
    end

    // History and bit count advance on accept; a lone resync just clears them.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            hist_r <= {HIST_W{1'b0}};
            cnt_r  <= 6'd0;
        end else if (accept_s) begin
            hist_r <= hist_next_s;
            cnt_r  <= cnt_next_s;
        end else if (resync) begin
            hist_r <= {HIST_W{1'b0}};
            cnt_r  <= 6'd0;
        end
    end

    // Output stage: load on accept, otherwise drain when downstream is ready.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= {DATA_W{1'b0}};
            out_hdr     <= 2'b00;
            out_trusted <= 1'b0;
            out_hdr_err <= 1'b0;
        end else if (accept_s) begin
            out_valid   <= 1'b1;
            out_data    <= bypass ? in_data : descr_s;
            out_hdr     <= in_hdr;
            out_trusted <= (cnt_eff_s >= 6'd58);
            out_hdr_err <= hdr_bad(in_hdr);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating count of accepted words carrying an invalid sync header.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            hdr_err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (accept_s && hdr_bad(in_hdr) && (hdr_err_cnt != {ERR_CNT_W{1'b1}})) begin
            hdr_err_cnt <= hdr_err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pcs_descrambler_param.sv
// Directed bench for pcs_descrambler_param: vector table plus serial-scrambler streams on 64- and 32-bit instances.
module tb_pcs_descrambler_param;

    logic        CLK = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        bypass;
    logic        resync;
    logic        out_ready;
    logic [1:0]  in_hdr;
    logic [63:0] a_in_data;
    logic [31:0] b_in_data;

    logic        a_in_ready, a_out_valid, a_out_trusted, a_out_hdr_err;
    logic [63:0] a_out_data;
    logic [1:0]  a_out_hdr;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_out_trusted, b_out_hdr_err;
    logic [31:0] b_out_data;
    logic [1:0]  b_out_hdr;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] orig [1000];
    logic [63:0] scr  [1000];

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic [63:0] exp_data;
        logic        exp_trust;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs [5];

    pcs_descrambler_param #(.DATA_W(64), .ERR_CNT_W(16)) u64 (
        .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_hdr(in_hdr), .bypass(bypass), .resync(resync),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_hdr(a_out_hdr), .out_trusted(a_out_trusted), .out_hdr_err(a_out_hdr_err),
        .hdr_err_cnt(a_cnt)
    );

    pcs_descrambler_param #(.DATA_W(32), .ERR_CNT_W(2)) u32 (
        .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_hdr(in_hdr), .bypass(bypass), .resync(resync),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_hdr(b_out_hdr), .out_trusted(b_out_trusted), .out_hdr_err(b_out_hdr_err),
        .hdr_err_cnt(b_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        bypass    = 1'b0;
        resync    = 1'b0;
        out_ready = 1'b1;
        in_hdr    = 2'b01;
        a_in_data = 64'd0;
        b_in_data = 32'd0;
        #1;
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_out_data", a_out_data, 64'd0);
        chk("rst_out_hdr", {62'd0, a_out_hdr}, 64'd0);
        chk("rst_trusted", {63'd0, a_out_trusted}, 64'd0);
        chk("rst_hdr_err", {63'd0, a_out_hdr_err}, 64'd0);
        chk("rst_cnt", {48'd0, a_cnt}, 64'd0);
        chk("rst_cnt32", {62'd0, b_cnt}, 64'd0);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_stream(input int w, input int n, input bit rnd, input bit special);
        logic [57:0] sr;
        logic [63:0] o, s, od;
        logic        sc, ov, ir, tr;
        int idx, out_idx, done, cyc;
        bit exp_ov, acc, trust_e;
        sr = {58{1'b1}};
        for (int j = 0; j < n; j++) begin
            o = {$urandom(), $urandom()};
            if (w == 32) o[63:32] = 32'd0;
            s = 64'd0;
            for (int b = 0; b < w; b++) begin
                sc   = o[b] ^ sr[38] ^ sr[57];
                s[b] = sc;
                sr   = {sr[56:0], sc};
            end
            orig[j] = o;
            scr[j]  = s;
        end
        idx = 0; out_idx = 0; done = 0; cyc = 0; exp_ov = 1'b0;
        while (done < n && cyc < n * 8 + 20) begin
            in_valid = (idx < n);
            if (idx < n) begin
                a_in_data = scr[idx];
                b_in_data = scr[idx][31:0];
            end
            bypass    = special && idx >= 9 && idx <= 11;
            resync    = special && idx == 19;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            ir = (w == 64) ? a_in_ready : b_in_ready;
            chk("in_ready", {63'd0, ir}, {63'd0, !exp_ov || out_ready});
            acc = in_valid && (!exp_ov || out_ready);
            if (exp_ov && out_ready) done++;
            @(posedge CLK);
            #1;
            cyc++;
            if (acc) begin
                exp_ov  = 1'b1;
                out_idx = idx;
                idx++;
            end else if (out_ready) begin
                exp_ov = 1'b0;
            end
            ov = (w == 64) ? a_out_valid : b_out_valid;
            tr = (w == 64) ? a_out_trusted : b_out_trusted;
            od = (w == 64) ? a_out_data : {32'd0, b_out_data};
            chk("stream_out_valid", {63'd0, ov}, {63'd0, exp_ov});
            if (exp_ov) begin
                trust_e = (w == 64) ? !(out_idx == 0 || (special && out_idx == 19)) : (out_idx >= 2);
                chk($sformatf("stream_trust[%0d]", out_idx), {63'd0, tr}, {63'd0, trust_e});
                if (special && out_idx >= 9 && out_idx <= 11) begin
                    chk($sformatf("bypass_data[%0d]", out_idx), od, scr[out_idx]);
                end else if (trust_e) begin
                    chk($sformatf("stream_data[%0d]", out_idx), od, orig[out_idx]);
                end
            end
        end
        in_valid = 1'b0;
        bypass   = 1'b0;
        resync   = 1'b0;
        if (done != n) chk("stream_timeout", 64'(done), 64'(n));
    endtask

    initial begin
        vecs[0] = '{64'h0000_0000_0000_0001, 2'b01, 64'h0400_0080_0000_0001, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{64'h0000_0000_0000_0000, 2'b00, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 16'd1};
        vecs[2] = '{64'h0000_0000_0000_0000, 2'b11, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 16'd2};
        vecs[3] = '{64'h8000_0000_0000_0000, 2'b10, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{64'h0000_0000_0000_0000, 2'b11, 64'h0200_0040_0000_0000, 1'b1, 1'b1, 16'd3};

        do_reset();
        for (int v = 0; v < 5; v++) begin
            in_valid  = 1'b1;
            a_in_data = vecs[v].data;
            b_in_data = vecs[v].data[31:0];
            in_hdr    = vecs[v].hdr;
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", v), {63'd0, a_out_valid}, 64'd1);
            chk($sformatf("vec%0d_data", v), a_out_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_trust", v), {63'd0, a_out_trusted}, {63'd0, vecs[v].exp_trust});
            chk($sformatf("vec%0d_hdr_err", v), {63'd0, a_out_hdr_err}, {63'd0, vecs[v].exp_err});
            chk($sformatf("vec%0d_hdr", v), {62'd0, a_out_hdr}, {62'd0, vecs[v].hdr});
            chk($sformatf("vec%0d_cnt", v), {48'd0, a_cnt}, {48'd0, vecs[v].exp_cnt});
        end
        chk("cnt32_after_table", {62'd0, b_cnt}, 64'd3);

        // Five more bad headers: wide counter keeps counting, 2-bit counter stays pinned.
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            a_in_data = 64'd0;
            b_in_data = 32'd0;
            in_hdr    = 2'b00;
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
        end
        in_hdr = 2'b01;
        chk("cnt64_after_8_bad", {48'd0, a_cnt}, 64'd8);
        chk("cnt32_saturated", {62'd0, b_cnt}, 64'd3);

        // Stall: hold data and valid while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in_data = 64'h1234_5678_9ABC_DEF0;
        @(posedge CLK);
        #1;
        chk("stall_in_ready", {63'd0, a_in_ready}, 64'd0);
        a_in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge CLK);
        #1;
        chk("stall_valid_hold", {63'd0, a_out_valid}, 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        do_reset();
        run_stream(64, 1000, 1'b0, 1'b0);
        do_reset();
        run_stream(64, 300, 1'b1, 1'b0);
        do_reset();
        run_stream(32, 200, 1'b0, 1'b0);
        do_reset();
        run_stream(32, 100, 1'b1, 1'b0);
        do_reset();
        run_stream(64, 30, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d, errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
